// File: rtl/da_pkg.sv
// rtl/da_pkg.sv - shared types and limits for the DA subfilter serial sequencer
package da_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DRAIN,
    OUT
  } da_seq_state_t;

  typedef struct packed {
    logic act;
    logic first;
    logic last;
  } da_ctrl_t;

  localparam int DA_MAX_ROM_LATENCY = 4;

  localparam da_ctrl_t DA_CTRL_NONE = '{act: 1'b0, first: 1'b0, last: 1'b0};

  function automatic da_ctrl_t da_issue_ctrl(input logic first_bit, input logic last_bit);
    return '{act: 1'b1, first: first_bit, last: last_bit};
  endfunction

endpackage

// File: rtl/da_ctrl_delay.sv
// rtl/da_ctrl_delay.sv - register chain that re-times arithmetic controls to the ROM output
module da_ctrl_delay
  import da_pkg::*;
#(
  parameter int DEPTH = 1
) (
  input  logic     clk,
  input  logic     rst_n,
  input  da_ctrl_t ctrl_i,
  output da_ctrl_t ctrl_o
);

  generate
    if (DEPTH == 0) begin : g_pass
      assign ctrl_o = ctrl_i;
    end else begin : g_chain
      da_ctrl_t stage_q [DEPTH];

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int i = 0; i < DEPTH; i++) stage_q[i] <= DA_CTRL_NONE;
        end else begin
          stage_q[0] <= ctrl_i;
          for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
        end
      end

      assign ctrl_o = stage_q[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/da_serial_sequencer.sv
// rtl/da_serial_sequencer.sv - serialises one sample into a DA subfilter and captures its result
module da_serial_sequencer
  import da_pkg::*;
#(
  parameter int word_width  = 16,
  parameter int ROM_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [word_width-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic                  D,
  output logic                  shift_en,
  output logic                  acc_en,
  output logic                  SWb,
  output logic                  Ts,
  output logic                  SWa,
  input  logic [word_width-1:0] y_in,
  output logic [word_width-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready
);

  localparam int W  = word_width;
  localparam int CW = $clog2(W);
  localparam int L  = (ROM_LATENCY > DA_MAX_ROM_LATENCY) ? DA_MAX_ROM_LATENCY : ROM_LATENCY;
  localparam logic [CW-1:0] LAST_BIT = CW'(W - 1);

  da_seq_state_t state_q;
  logic [W-1:0]  sample_q;
  logic [CW-1:0] bit_cnt_q;
  logic [CW-1:0] bit_cnt_d;
  logic          d_q;
  logic          shift_en_q;
  logic          in_ready_q;
  logic [W-1:0]  out_data_q;
  logic          out_valid_q;
  da_ctrl_t      issue_q;
  da_ctrl_t      issue_d;
  da_ctrl_t      ctrl_dly;
  logic          last_bit;

  // Controls are issued alongside each serial bit, then delayed to meet the ROM data.
  da_ctrl_delay #(
    .DEPTH (L)
  ) u_ctrl_delay (
    .clk    (clk),
    .rst_n  (rst),
    .ctrl_i (issue_q),
    .ctrl_o (ctrl_dly)
  );

  always_comb begin
    bit_cnt_d = bit_cnt_q + 1'b1;
    last_bit  = (bit_cnt_q == LAST_BIT);
    issue_d   = da_issue_ctrl(1'b0, bit_cnt_d == LAST_BIT);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      sample_q    <= '0;
      bit_cnt_q   <= '0;
      d_q         <= 1'b0;
      shift_en_q  <= 1'b0;
      in_ready_q  <= 1'b0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      issue_q     <= DA_CTRL_NONE;
    end else begin
      case (state_q)
        IDLE: begin
          in_ready_q <= 1'b1;
          if (in_valid && in_ready_q) begin
            sample_q   <= in_data;
            bit_cnt_q  <= '0;
            d_q        <= in_data[0];
            shift_en_q <= 1'b1;
            issue_q    <= da_issue_ctrl(1'b1, 1'b0);
            in_ready_q <= 1'b0;
            state_q    <= SHIFT;
          end
        end
        SHIFT: begin
          if (last_bit) begin
            d_q        <= 1'b0;
            shift_en_q <= 1'b0;
            issue_q    <= DA_CTRL_NONE;
            state_q    <= DRAIN;
          end else begin
            bit_cnt_q <= bit_cnt_d;
            d_q       <= sample_q[bit_cnt_d];
            issue_q   <= issue_d;
          end
        end
        DRAIN: begin
          issue_q <= DA_CTRL_NONE;
        end
        OUT: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase

      // With zero ROM latency the final bit and the capture share one edge, skipping DRAIN.
      if ((state_q == SHIFT || state_q == DRAIN) && ctrl_dly.last) begin
        out_data_q  <= y_in;
        out_valid_q <= 1'b1;
        state_q     <= OUT;
      end
    end
  end

  assign in_ready  = in_ready_q;
  assign D         = d_q;
  assign shift_en  = shift_en_q;
  assign acc_en    = ctrl_dly.act;
  assign SWb       = ctrl_dly.first;
  assign Ts        = ctrl_dly.last;
  assign SWa       = ctrl_dly.last;
  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_da_serial_sequencer.sv
// tb/tb_da_serial_sequencer.sv - directed bench for the DA serial sequencer at ROM latencies 0, 1 and 3
module tb_da_serial_sequencer;

  localparam int W = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] in_data;
  logic        in_valid;
  logic        out_ready;
  logic [15:0] y_in;

  logic        ir_w  [3];
  logic        d_w   [3];
  logic        sh_w  [3];
  logic        acc_w [3];
  logic        swb_w [3];
  logic        ts_w  [3];
  logic        swa_w [3];
  logic        ov_w  [3];
  logic [15:0] od_w  [3];

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  da_serial_sequencer #(.word_width(16), .ROM_LATENCY(0)) u_l0 (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(ir_w[0]),
    .D(d_w[0]), .shift_en(sh_w[0]), .acc_en(acc_w[0]), .SWb(swb_w[0]), .Ts(ts_w[0]),
    .SWa(swa_w[0]), .y_in(y_in), .out_data(od_w[0]), .out_valid(ov_w[0]), .out_ready(out_ready)
  );

  da_serial_sequencer #(.word_width(16), .ROM_LATENCY(1)) u_l1 (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(ir_w[1]),
    .D(d_w[1]), .shift_en(sh_w[1]), .acc_en(acc_w[1]), .SWb(swb_w[1]), .Ts(ts_w[1]),
    .SWa(swa_w[1]), .y_in(y_in), .out_data(od_w[1]), .out_valid(ov_w[1]), .out_ready(out_ready)
  );

  da_serial_sequencer #(.word_width(16), .ROM_LATENCY(3)) u_l3 (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(ir_w[2]),
    .D(d_w[2]), .shift_en(sh_w[2]), .acc_en(acc_w[2]), .SWb(swb_w[2]), .Ts(ts_w[2]),
    .SWa(swa_w[2]), .y_in(y_in), .out_data(od_w[2]), .out_valid(ov_w[2]), .out_ready(out_ready)
  );

  function automatic int lat_of(input int i);
    return (i == 0) ? 0 : ((i == 1) ? 1 : 3);
  endfunction

  function automatic logic [15:0] yv(input int k);
    return 16'hC300 ^ 16'(k * 37);
  endfunction

  // Bit order: in_ready, D, shift_en, acc_en, SWb, Ts, SWa, out_valid
  function automatic logic [7:0] act_vec(input int i);
    return {ir_w[i], d_w[i], sh_w[i], acc_w[i], swb_w[i], ts_w[i], swa_w[i], ov_w[i]};
  endfunction

  // Cycle k after the accept edge; rdy means out_ready is held high throughout.
  function automatic logic [7:0] exp_vec(input logic [15:0] s, input int L, input int k, input bit rdy);
    logic ir, d, sh, acc, swb, ts, ov;
    sh  = (k >= 1 && k <= W);
    d   = sh ? s[4'(k - 1)] : 1'b0;
    acc = (k >= 1 + L && k <= W + L);
    swb = (k == 1 + L);
    ts  = (k == W + L);
    ov  = rdy ? (k == W + L + 1) : (k >= W + L + 1);
    ir  = rdy && (k >= W + L + 3);
    return {ir, d, sh, acc, swb, ts, ts, ov};
  endfunction

  task automatic do_reset();
    rst       = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_data   = 16'h0000;
    y_in      = 16'h0000;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    for (int c = 0; c < 5; c++) begin
      in_data   = 16'($urandom);
      in_valid  = 1'($urandom);
      out_ready = 1'($urandom);
      y_in      = 16'($urandom);
      @(posedge clk); #1;
      for (int i = 0; i < 3; i++) begin
        nvec++;
        if (act_vec(i) !== 8'h00) begin
          nerr++;
          $display("FAIL reset_ctrl L=%0d got %b want %b", lat_of(i), act_vec(i), 8'h00);
        end
        nvec++;
        if (od_w[i] !== 16'h0000) begin
          nerr++;
          $display("FAIL reset_out_data L=%0d got %h want %h", lat_of(i), od_w[i], 16'h0000);
        end
      end
    end
    in_valid = 1'b0;
    rst      = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) begin
      nvec++;
      if (act_vec(i) !== 8'h00) begin
        nerr++;
        $display("FAIL release_before_edge L=%0d got %b want %b", lat_of(i), act_vec(i), 8'h00);
      end
    end
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) begin
      nvec++;
      if (act_vec(i) !== 8'h80) begin
        nerr++;
        $display("FAIL release_in_ready L=%0d got %b want %b", lat_of(i), act_vec(i), 8'h80);
      end
    end
  endtask

  task automatic test_basic();
    logic [7:0] e;
    do_reset();
    in_data  = 16'h8001;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int k = 1; k <= 21; k++) begin
      y_in = yv(k);
      for (int i = 0; i < 3; i++) begin
        e = exp_vec(16'h8001, lat_of(i), k, 1'b0);
        nvec++;
        if (act_vec(i) !== e) begin
          nerr++;
          $display("FAIL basic_ctrl L=%0d cycle %0d got %b want %b", lat_of(i), k, act_vec(i), e);
        end
        if (e[0]) begin
          nvec++;
          if (od_w[i] !== yv(W + lat_of(i))) begin
            nerr++;
            $display("FAIL basic_out_data L=%0d cycle %0d got %h want %h", lat_of(i), k, od_w[i], yv(W + lat_of(i)));
          end
        end
      end
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      nvec++;
      if (act_vec(i) !== 8'h00) begin
        nerr++;
        $display("FAIL basic_handshake L=%0d got %b want %b", lat_of(i), act_vec(i), 8'h00);
      end
    end
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) begin
      nvec++;
      if (act_vec(i) !== 8'h80) begin
        nerr++;
        $display("FAIL basic_idle_ready L=%0d got %b want %b", lat_of(i), act_vec(i), 8'h80);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] e;
    do_reset();
    in_data  = 16'h5A3C;
    in_valid = 1'b1;
    @(posedge clk); #1;
    for (int k = 1; k <= W + 3 + 11; k++) begin
      in_data = 16'($urandom);
      y_in    = yv(k + 100);
      for (int i = 0; i < 3; i++) begin
        e = exp_vec(16'h5A3C, lat_of(i), k, 1'b0);
        nvec++;
        if (act_vec(i) !== e) begin
          nerr++;
          $display("FAIL bp_ctrl L=%0d cycle %0d got %b want %b", lat_of(i), k, act_vec(i), e);
        end
        if (e[0]) begin
          nvec++;
          if (od_w[i] !== yv(W + lat_of(i) + 100)) begin
            nerr++;
            $display("FAIL bp_out_data L=%0d cycle %0d got %h want %h", lat_of(i), k, od_w[i], yv(W + lat_of(i) + 100));
          end
        end
      end
      @(posedge clk); #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      nvec++;
      if (act_vec(i) !== 8'h00) begin
        nerr++;
        $display("FAIL bp_release L=%0d got %b want %b", lat_of(i), act_vec(i), 8'h00);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0]  e;
    logic [15:0] s;
    int          o, kk, seg;
    do_reset();
    out_ready = 1'b1;
    in_data   = 16'h7FFF;
    in_valid  = 1'b1;
    @(posedge clk); #1;
    in_data = 16'hFFFF;
    for (int k = 1; k <= 45; k++) begin
      y_in = yv(k + 200);
      for (int i = 0; i < 3; i++) begin
        o   = W + lat_of(i) + 3;
        kk  = k;
        seg = 0;
        while (kk > o) begin
          kk  -= o;
          seg += 1;
        end
        s = (seg == 0) ? 16'h7FFF : 16'hFFFF;
        e = exp_vec(s, lat_of(i), kk, 1'b1);
        nvec++;
        if (act_vec(i) !== e) begin
          nerr++;
          $display("FAIL b2b_ctrl L=%0d cycle %0d got %b want %b", lat_of(i), k, act_vec(i), e);
        end
        if (e[0]) begin
          nvec++;
          if (od_w[i] !== yv(seg * o + W + lat_of(i) + 200)) begin
            nerr++;
            $display("FAIL b2b_out_data L=%0d cycle %0d got %h want %h", lat_of(i), k, od_w[i], yv(seg * o + W + lat_of(i) + 200));
          end
        end
      end
      @(posedge clk); #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic [7:0] e;
    do_reset();
    in_data  = 16'h3C5A;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int k = 1; k < 8; k++) begin
      @(posedge clk); #1;
    end
    e = exp_vec(16'h3C5A, 1, 8, 1'b0);
    nvec++;
    if (act_vec(1) !== e) begin
      nerr++;
      $display("FAIL mid_progress L=1 got %b want %b", act_vec(1), e);
    end
    rst = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      nvec++;
      if (act_vec(i) !== 8'h00 || od_w[i] !== 16'h0000) begin
        nerr++;
        $display("FAIL mid_reset L=%0d got %b/%h want %b/%h", lat_of(i), act_vec(i), od_w[i], 8'h00, 16'h0000);
      end
    end
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) begin
      nvec++;
      if (act_vec(i) !== 8'h80) begin
        nerr++;
        $display("FAIL mid_recover L=%0d got %b want %b", lat_of(i), act_vec(i), 8'h80);
      end
    end
    out_ready = 1'b1;
    in_data   = 16'hA5C3;
    in_valid  = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int k = 1; k <= 22; k++) begin
      y_in = yv(k + 300);
      for (int i = 0; i < 3; i++) begin
        e = exp_vec(16'hA5C3, lat_of(i), k, 1'b1);
        nvec++;
        if (act_vec(i) !== e) begin
          nerr++;
          $display("FAIL mid_next_ctrl L=%0d cycle %0d got %b want %b", lat_of(i), k, act_vec(i), e);
        end
        if (e[0]) begin
          nvec++;
          if (od_w[i] !== yv(W + lat_of(i) + 300)) begin
            nerr++;
            $display("FAIL mid_next_out_data L=%0d cycle %0d got %h want %h", lat_of(i), k, od_w[i], yv(W + lat_of(i) + 300));
          end
        end
      end
      @(posedge clk); #1;
    end
    out_ready = 1'b0;
  endtask

  initial begin
    rst       = 1'b0;
    in_data   = 16'h0000;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    y_in      = 16'h0000;
    #2;
    test_reset();
    test_basic();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout after %0t want finish before %0t", $time, 200000);
    $fatal(1, "timeout");
  end

endmodule
